sync_pkt_fifo_fwft: RTL and testbench
=====================================

# sync_pkt_fifo_fwft

Single-clock, first-word-fall-through packet FIFO with commit/rollback semantics, for the USB driver datapath between the packet assembler and the endpoint transmit engine. Words are written speculatively and become readable only when the packet's last word is accepted; a partial packet can be discarded without disturbing committed data. Provides word and packet occupancy, a programmable almost-full flag, and per-word end-of-packet marking on the read side.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 512, storage depth in words; power of two, ≥ 4.
- `AFULL_TH`, 448, `afull` asserts when `wr_usedw` ≥ `AFULL_TH`; legal range 1..`DEPTH`.
- `AW`, localparam, `log2(DEPTH)`.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write request.
- `wr_data` in `WIDTH`: write word.
- `wr_last` in 1: qualifies `wr_en`; the word is the last of its packet and commits it.
- `wr_drop` in 1: discard the uncommitted packet.
- `full` out 1: `wr_usedw == DEPTH`.
- `afull` out 1: almost full.
- `ovf` out 1: sticky overflow, set when a write is attempted while full.
- `wr_usedw` out `AW+1`: words held, committed plus uncommitted.
- `rd_en` in 1: pop request; ignored when `rd_valid` = 0.
- `rd_data` out `WIDTH`: head word, valid when `rd_valid` = 1.
- `rd_last` out 1: the head word ends its packet.
- `rd_valid` out 1: at least one committed word is present.
- `rd_usedw` out `AW+1`: committed words readable.
- `pkt_cnt` out `AW+1`: complete packets held.

## Operation
- Storage is `DEPTH` × (`WIDTH`+1); the extra bit stores `wr_last`.
- There are three `AW+1`-bit binary pointers: `wp` (write), `cp` (commit), `rp` (read). The low `AW` bits address storage and the MSB is the wrap bit.
- `wr_usedw = wp - rp` and `rd_usedw = cp - rp`, both modulo 2^(`AW`+1).
- `rd_valid = (cp != rp)`.
- `rd_data` and `rd_last` are combinational reads of `mem[rp]`; this gives first-word-fall-through with no read latency.
- A write is accepted when `wr_en` = 1 and `full` = 0. On acceptance, store {`wr_last`, `wr_data`} at `wp` and increment `wp`. If `wr_last` = 1, `cp` becomes the new `wp` and `pkt_cnt` increments.
- A write with `full` = 1 is ignored, including its `wr_last`, and `ovf` sets.
- A pop occurs when `rd_en` = 1 and `rd_valid` = 1: `rp` increments. If `rd_last` = 1, `pkt_cnt` decrements.
- If a commit and a last-word pop occur in the same cycle, `pkt_cnt` is unchanged.
- Drop (`wr_drop` = 1): `wp` is loaded with `cp`, `ovf` clears, and any accepted-write effects in that cycle are cancelled (drop wins over a simultaneous write or `wr_last`).
- While `ovf` = 1, an accepted `wr_last` word performs a drop instead of a commit. A truncated packet is therefore never exposed.
- Packets must be ≤ `DEPTH` words. A packet that fills the FIFO with `cp == rp` can only be recovered by a drop.
- Reads and writes in the same cycle are independent. A word committed at edge N is not poppable at edge N.

## Timing
- Reset values: `wp` = `cp` = `rp` = 0, `pkt_cnt` = 0, `ovf` = 0, `full` = 0, `afull` = 0, `wr_usedw` = `rd_usedw` = 0, `rd_valid` = 0. `rd_data`/`rd_last` reflect `mem[0]` and are don't-care.
- Storage is not reset.
- Commit to visibility: a `wr_last` accepted at edge N gives `rd_valid` = 1 and an updated `rd_usedw`/`pkt_cnt` from edge N (that is, in cycle N+1).
- `full`, `afull` and `wr_usedw` update at the same edge as the write, pop or drop that changes them.
- Deasserting `rst_n` at any time, including mid-packet, returns everything to reset values immediately and asynchronously. All data is lost.
- Pointer wrap: the MSB toggles every `DEPTH` words. Full versus empty is distinguished by the wrap bit; no state is lost at the wrap.

## Configuration
- `SYNC_PKT_FIFO_DROP_EN` defined: `wr_drop`, `ovf` auto-drop and rollback behave as specified above.
- Undefined: `wr_drop` is ignored.
  - `ovf` still sets on a write while full and clears only by reset.
  - `wr_last` always commits, even if words were lost.
  - `cp` logic reduces to tracking `wp` at `wr_last`.

## Test plan
- Reset, then write 3 words (0x11, 0x22, 0x33, with `wr_last` on 0x33): `rd_valid` stays 0 until the edge accepting 0x33; then `rd_usedw` = 3, `pkt_cnt` = 1; pops return 0x11, 0x22, 0x33 with `rd_last` = 1 only on 0x33.
- Write 4 words without `wr_last`, then pulse `wr_drop`: `wr_usedw` returns to 0, `rd_valid` never asserts, and a following 2-word packet reads back correctly.
- `DEPTH` = 8: write a 5-word packet, then a 6-word packet; the 4th word of the second packet hits `full`, `ovf` = 1, and its `wr_last` auto-drops; only the first packet is readable and `wr_usedw` = 5. Without the macro, a 6-word packet with a lost word commits instead, giving `pkt_cnt` = 2 and `rd_usedw` = 8.
- Concurrent streaming of 1000 random-length packets (1–8 words, `DEPTH` = 8) with random `rd_en`: data order, `rd_last` positions and `pkt_cnt` match the model, and pointers wrap many times.
- Same-cycle commit and last-word pop: `pkt_cnt` holds 1; `afull` asserts exactly at `wr_usedw` = `AFULL_TH`.
- Assert `rst_n` low mid-packet and mid-read: all outputs reach reset values asynchronously, and the next packet works.

Source files
------------

// File: rtl/sync_pkt_fifo_fwft.sv
// Single-clock first-word-fall-through packet FIFO with commit/rollback semantics.
// Optional feature macro: SYNC_PKT_FIFO_DROP_EN enables wr_drop, ovf auto-drop and rollback.
module sync_pkt_fifo_fwft #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 512,
   parameter int AFULL_TH = 448,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_last,
   input  logic             wr_drop,
   output logic             full,
   output logic             afull,
   output logic             ovf,
   output logic [AW:0]      wr_usedw,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_last,
   output logic             rd_valid,
   output logic [AW:0]      rd_usedw,
   output logic [AW:0]      pkt_cnt
);

   localparam logic [AW:0] ONE       = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_TH);

   logic [WIDTH:0] mem_q [DEPTH];
   logic [AW:0]    wp_q, wp_d, cp_q, cp_d, rp_q, rp_d, pkt_q, pkt_d;
   logic           ovf_q, ovf_d;
   logic           accept, overrun, pop, commit;
   logic [WIDTH:0] head;

   assign wr_usedw = wp_q - rp_q;
   assign rd_usedw = cp_q - rp_q;
   assign full     = (wr_usedw == FULL_CNT);
   assign afull    = (wr_usedw >= AFULL_CNT);
   assign ovf      = ovf_q;
   assign pkt_cnt  = pkt_q;
   assign rd_valid = (cp_q != rp_q);

   assign head     = mem_q[rp_q[AW-1:0]];
   assign rd_data  = head[WIDTH-1:0];
   assign rd_last  = head[WIDTH];

   assign accept   = wr_en & ~full;
   assign overrun  = wr_en & full;
   assign pop      = rd_en & rd_valid;

`ifdef SYNC_PKT_FIFO_DROP_EN
   logic drop;

   // A wr_last that arrives after (or as) words were lost closes the packet by rolling it back.
   always_comb begin
      drop   = wr_drop | (wr_en & wr_last & (ovf_q | overrun));
      commit = accept & wr_last & ~ovf_q & ~wr_drop;
      wp_d   = accept ? wp_q + ONE : wp_q;
      cp_d   = commit ? wp_q + ONE : cp_q;
      ovf_d  = ovf_q | overrun;
      if (drop) begin
         wp_d  = cp_q;
         ovf_d = 1'b0;
      end
   end
`else
   logic drop_unused;
   assign drop_unused = wr_drop;

   // wr_last always closes the packet, even when it was rejected for lack of space.
   always_comb begin
      wp_d   = accept ? wp_q + ONE : wp_q;
      commit = wr_en & wr_last & (accept | (wp_q != cp_q));
      cp_d   = commit ? wp_d : cp_q;
      ovf_d  = ovf_q | overrun;
   end
`endif

   always_comb begin
      rp_d = pop ? rp_q + ONE : rp_q;
      case ({commit, pop & head[WIDTH]})
         2'b10:   pkt_d = pkt_q + ONE;
         2'b01:   pkt_d = pkt_q - ONE;
         default: pkt_d = pkt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         cp_q  <= '0;
         rp_q  <= '0;
         pkt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         cp_q  <= cp_d;
         rp_q  <= rp_d;
         pkt_q <= pkt_d;
         ovf_q <= ovf_d;
      end
   end

   // Storage carries no reset; only slots below the commit pointer are ever exposed.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wp_q[AW-1:0]] <= {wr_last, wr_data};
      end
   end

endmodule

// File: tb/tb_sync_pkt_fifo_fwft.sv
// Directed-vector bench for sync_pkt_fifo_fwft (DEPTH=8, AFULL_TH=6) plus a packet-stream model.
module tb_sync_pkt_fifo_fwft;

   localparam int W   = 8;
   localparam int D   = 8;
   localparam int AW  = 3;
   localparam int AFT = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0, wr_last = 1'b0, wr_drop = 1'b0, rd_en = 1'b0;
   logic [W-1:0]  wr_data = '0;
   logic          full, afull, ovf, rd_last, rd_valid;
   logic [W-1:0]  rd_data;
   logic [AW:0]   wr_usedw, rd_usedw, pkt_cnt;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic       wrEn;
      logic [7:0] wrData;
      logic       wrLast;
      logic       rdEn;
      logic       expValid;
      logic [7:0] expData;
      logic       expLast;
      int         expWu;
      int         expRu;
      int         expPkt;
      logic       expAfull;
      logic       expFull;
   } vec_t;

   vec_t vecs[$];

   sync_pkt_fifo_fwft #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AFT)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_drop(wr_drop),
      .full(full), .afull(afull), .ovf(ovf), .wr_usedw(wr_usedw),
      .rd_en(rd_en), .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid),
      .rd_usedw(rd_usedw), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkVec(logic we, logic [7:0] wd, logic wl, logic re,
                                  logic ev, logic [7:0] ed, logic el,
                                  int wu, int ru, int pk, logic af, logic fu);
      vec_t v;
      v.wrEn = we; v.wrData = wd; v.wrLast = wl; v.rdEn = re;
      v.expValid = ev; v.expData = ed; v.expLast = el;
      v.expWu = wu; v.expRu = ru; v.expPkt = pk; v.expAfull = af; v.expFull = fu;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic wl,
                                input logic wdrop, input logic re);
      wr_en = we; wr_data = wd; wr_last = wl; wr_drop = wdrop; rd_en = re;
      tick();
      wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
   endtask

   task automatic checkCounts(input string tag, input int wu, input int ru, input int pk,
                              input logic valid);
      checkOutput({tag, "_wr_usedw"}, int'(wr_usedw), wu);
      checkOutput({tag, "_rd_usedw"}, int'(rd_usedw), ru);
      checkOutput({tag, "_pkt_cnt"}, int'(pkt_cnt), pk);
      checkOutput({tag, "_rd_valid"}, int'(rd_valid), int'(valid));
   endtask

   task automatic checkHead(input string tag, input logic [7:0] data, input logic last);
      checkOutput({tag, "_rd_data"}, int'(rd_data), int'(data));
      checkOutput({tag, "_rd_last"}, int'(rd_last), int'(last));
   endtask

   task automatic checkResetState(input string tag);
      checkCounts(tag, 0, 0, 0, 1'b0);
      checkOutput({tag, "_full"}, int'(full), 0);
      checkOutput({tag, "_afull"}, int'(afull), 0);
      checkOutput({tag, "_ovf"}, int'(ovf), 0);
   endtask

   task automatic doReset(input string tag);
      wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      checkResetState(tag);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   logic [8:0] mw [0:16383];

   initial begin
      vec_t v;
      int   wpM, cpM, rpM, pktM, pktsDone, idx, len, cycles, dataCtr;
      logic doWr, doRd, lastNow;

      // Vector table: single packet, empty-pop, commit+pop same cycle, afull/full boundary.
      vecs.push_back(mkVec(1, 8'h11, 0, 0,  0, 8'h00, 0,  1, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h22, 0, 0,  0, 8'h00, 0,  2, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h33, 1, 0,  1, 8'h11, 0,  3, 3, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 1,  1, 8'h22, 0,  2, 2, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 1,  1, 8'h33, 1,  1, 1, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 1,  0, 8'h00, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 1,  0, 8'h00, 0,  0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 8'h44, 1, 0,  1, 8'h44, 1,  1, 1, 1, 0, 0));
      vecs.push_back(mkVec(1, 8'h55, 1, 1,  1, 8'h55, 1,  1, 1, 1, 0, 0));
      vecs.push_back(mkVec(0, 8'h00, 0, 1,  0, 8'h00, 0,  0, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) begin
         vecs.push_back(mkVec(1, 8'(8'h60 + k), logic'(k == 7), 0,
                              logic'(k == 7), 8'h60, 0,
                              k + 1, (k == 7) ? 8 : 0, (k == 7) ? 1 : 0,
                              logic'(k + 1 >= AFT), logic'(k == 7)));
      end
      for (int k = 1; k <= 8; k++) begin
         vecs.push_back(mkVec(0, 8'h00, 0, 1,
                              logic'(k < 8), 8'(8'h60 + k), logic'(k == 7),
                              8 - k, 8 - k, (k < 8) ? 1 : 0,
                              logic'(8 - k >= AFT), 0));
      end

      doReset("reset0");
      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         v = vecs[i];
         tag = $sformatf("vec%0d", i);
         applyStimulus(v.wrEn, v.wrData, v.wrLast, 1'b0, v.rdEn);
         checkCounts(tag, v.expWu, v.expRu, v.expPkt, v.expValid);
         checkOutput({tag, "_afull"}, int'(afull), int'(v.expAfull));
         checkOutput({tag, "_full"}, int'(full), int'(v.expFull));
         if (v.expValid) checkHead(tag, v.expData, v.expLast);
      end

      // Partial packet then drop, followed by a clean 2-word packet.
      doReset("reset1");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 8'(8'hD0 + k), 0, 0, 0);
         checkCounts($sformatf("part%0d", k), k + 1, 0, 0, 1'b0);
      end
      applyStimulus(0, 8'h00, 0, 1, 0);
`ifdef SYNC_PKT_FIFO_DROP_EN
      checkCounts("drop", 0, 0, 0, 1'b0);
      applyStimulus(1, 8'hA1, 0, 0, 0);
      applyStimulus(1, 8'hA2, 1, 0, 0);
      checkCounts("after_drop", 2, 2, 1, 1'b1);
      checkHead("after_drop", 8'hA1, 1'b0);
      applyStimulus(0, 8'h00, 0, 0, 1);
      checkHead("after_drop_pop1", 8'hA2, 1'b1);
      applyStimulus(0, 8'h00, 0, 0, 1);
      checkCounts("after_drop_pop2", 0, 0, 0, 1'b0);
      applyStimulus(1, 8'hB1, 1, 1, 0);
      checkCounts("drop_wins", 0, 0, 0, 1'b0);
`else
      checkCounts("drop_ignored", 4, 0, 0, 1'b0);
      applyStimulus(1, 8'hA1, 0, 0, 0);
      applyStimulus(1, 8'hA2, 1, 0, 0);
      checkCounts("after_drop_ignored", 6, 6, 1, 1'b1);
      checkHead("after_drop_ignored", 8'hD0, 1'b0);
`endif

      // Overflow: 5-word packet, then a 6-word packet that loses its last three words.
      doReset("reset2");
      for (int k = 1; k <= 5; k++) applyStimulus(1, 8'(k), logic'(k == 5), 0, 0);
      checkCounts("pkt5", 5, 5, 1, 1'b1);
      for (int k = 1; k <= 3; k++) applyStimulus(1, 8'(8'h10 + k), 0, 0, 0);
      checkOutput("fill_full", int'(full), 1);
      checkOutput("fill_ovf", int'(ovf), 0);
      applyStimulus(1, 8'h14, 0, 0, 0);
      checkOutput("ovf_set", int'(ovf), 1);
      checkCounts("ovf_set", 8, 5, 1, 1'b1);
      applyStimulus(1, 8'h15, 0, 0, 0);
      applyStimulus(1, 8'h16, 1, 0, 0);
`ifdef SYNC_PKT_FIFO_DROP_EN
      checkCounts("autodrop", 5, 5, 1, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         checkHead($sformatf("autodrop_rd%0d", k), 8'(k), logic'(k == 5));
         applyStimulus(0, 8'h00, 0, 0, 1);
      end
      checkCounts("autodrop_empty", 0, 0, 0, 1'b0);
`else
      checkCounts("lossy_commit", 8, 8, 2, 1'b1);
      checkOutput("lossy_ovf", int'(ovf), 1);
`endif

      // Asynchronous reset mid-packet and mid-read.
      doReset("reset3");
      applyStimulus(1, 8'h81, 0, 0, 0);
      applyStimulus(1, 8'h82, 1, 0, 0);
      applyStimulus(1, 8'h83, 0, 0, 1);
      checkCounts("pre_async", 2, 1, 1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("async");
      #2;
      rst_n = 1'b1;
      tick();
      applyStimulus(1, 8'h99, 1, 0, 0);
      checkCounts("post_async", 1, 1, 1, 1'b1);
      checkHead("post_async", 8'h99, 1'b1);

      // Concurrent stream of random-length packets against a pointer model.
      doReset("reset4");
      wpM = 0; cpM = 0; rpM = 0; pktM = 0; pktsDone = 0; idx = 0; cycles = 0; dataCtr = 0;
      len = $urandom_range(1, 8);
      while ((pktsDone < 1000 || rpM < cpM) && cycles < 30000) begin
         checkCounts("stream", wpM - rpM, cpM - rpM, pktM, logic'(cpM > rpM));
         if (cpM > rpM) checkHead("stream", mw[rpM][7:0], mw[rpM][8]);
         doWr    = (pktsDone < 1000) && ((wpM - rpM) < D);
         doRd    = logic'($urandom_range(0, 1));
         lastNow = (idx == len - 1);
         wr_en = doWr; wr_data = 8'(dataCtr); wr_last = doWr & lastNow; rd_en = doRd;
         if (doRd && cpM > rpM) begin
            if (mw[rpM][8]) pktM--;
            rpM++;
         end
         if (doWr) begin
            mw[wpM] = {lastNow, 8'(dataCtr)};
            wpM++;
            dataCtr++;
            if (lastNow) begin
               cpM = wpM;
               pktM++;
               pktsDone++;
               idx = 0;
               len = $urandom_range(1, 8);
            end else begin
               idx++;
            end
         end
         tick();
         cycles++;
      end
      wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
      checkOutput("stream_in_budget", int'(cycles < 30000), 1);
      checkCounts("stream_end", 0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
